hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
// - Decode-stage RAW hazard scoreboard for the 5-stage 16-bit pipeline; sits beside the bypassing register file.
// - Tracks in-flight writes per architectural register between decode issue and writeback retirement.
// - Raises stall to hold IF/ID and inject an ID/EX bubble while a source register has an unretired write.
// - Same-cycle writeback is not a hazard: the register file forwards writeback data to decode reads that cycle.
// PARAMETERS
// - NREG  8  architectural register count
// - SELW  3  register select width, log2(NREG)
// - CNTW  2  per-register pending counter width; covers at most 3 in-flight writes (EX, MEM, WB)
// PORTS
// - clk        in   1     clock; all state updates on rising edge
// - rst        in   1     asynchronous, active-high reset
// - id_valid   in   1     decode holds a real instruction (not a bubble)
// - rs_sel     in   SELW  first source register select (same value the register file gets on readReg1Sel)
// - rs_used    in   1     instruction reads rs
// - rt_sel     in   SELW  second source register select (readReg2Sel)
// - rt_used    in   1     instruction reads rt
// - dst_sel    in   SELW  destination register of the decode instruction
// - dst_en     in   1     decode instruction writes dst_sel
// - wb_sel     in   SELW  writeback destination (writeRegSel of the register file)
// - wb_en      in   1     writeback commits this cycle (writeEn)
// - kill_sel   in   SELW  destination of an in-flight write squashed by branch/jump flush
// - kill_en    in   1     squash one pending write to kill_sel this cycle
// - stall      out  1     hold PC and IF/ID; force ID/EX to a bubble
// - err        out  1     sticky: counter overflow or underflow detected
// BEHAVIOUR
// - Reset (async assert, sync release): all pending counters 0, err 0; stall therefore 0.
// - hit(r) = pend[r] > (wb_en & wb_sel==r ? 1 : 0), plus any wb_en&wb_sel==r with pend[r]==0 is ignored.
// - stall = id_valid & ((rs_used & hit(rs_sel)) | (rt_used & hit(rt_sel))); combinational from registered counters.
// - issue = id_valid & ~stall & dst_en. Issue on stall is forbidden; a stalled instruction re-presents next cycle.
// - Per register r, next count = pend[r] + inc - dec, all applied in one cycle:
//   inc = issue & dst_sel==r; dec = (wb_en & wb_sel==r) + (kill_en & kill_sel==r).
// - Simultaneous inc and dec on same r: net result, e.g. pend 1, issue+wb -> stays 1.
// - Overflow (result > 2^CNTW-1) or underflow (dec exceeds pend): counter saturates, err set and held until rst.
// - r0 is an ordinary tracked register (no hardwired zero in this ISA).
// - Latency: issue visible in stall of the following cycle; writeback clears hazard in the same cycle.
// - Reset mid-operation: counters clear immediately; pipeline flush is the caller's responsibility.
// CONFIGURATION
// - Macro HAZARD_SCOREBOARD_STATS_EN:
//   defined: extra output stall_cycles [15:0], counts cycles with stall=1, wraps 0xFFFF->0, cleared by rst.
//   undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
// - Shared package: NREG, SELW, CNTW constants; REG_SEL_T typedef for register selects.
// - Sub-module scbd_counter: one CNTW-bit up/down counter with inc, dec0, dec1, saturation and overflow/underflow
//   flag; instantiated NREG times via generate; top handles decode of selects, stall, err OR-reduction.
// TESTING
// - Reset: rst pulse mid-clock with pend[3]=2 -> counters 0, stall 0, err 0 immediately.
// - RAW stall: issue dst=2, next cycle id_valid rs=2 rs_used -> stall=1 until wb_en wb_sel=2; stall=0 that cycle.
// - Same-cycle bypass: pend[5]=1, wb_en wb_sel=5, rt=5 rt_used -> stall=0, pend[5] goes 0.
// - Unused operand: pend[4]=1, rs_sel=4 rs_used=0 -> stall=0; issue dst=4 -> pend[4]=2.
// - Kill plus writeback same reg same cycle: pend[6]=2, kill_en+wb_en on 6 -> pend[6]=0, err stays 0.
// - Error: wb_en wb_sel=1 with pend[1]=0 -> err=1 sticky; four issues to dst=7 w/o wb -> err=1, pend[7]=3.
// - STATS_EN build: hold hazard 5 cycles -> stall_cycles=5.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the decode-stage RAW hazard scoreboard.
// Register count, select width and pending-counter width live here.
package hazard_scoreboard_pkg;

    localparam int NREG = 8;
    localparam int SELW = 3;
    localparam int CNTW = 2;

    typedef logic [SELW-1:0] REG_SEL_T;
    typedef logic [CNTW-1:0] CNT_T;

    localparam CNT_T CNT_MAX = '1;

endpackage

// File: rtl/hazard_scoreboard_scbd_counter.sv
// One saturating pending-write counter: one increment and two decrements per cycle.
// The fault output flags an overflow or underflow of the update in flight.
module scbd_counter
    import hazard_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec0,
    input  logic dec1,
    output CNT_T count,
    output logic fault
);

    localparam int W = CNTW + 1;

    logic [W-1:0] sumUp;
    logic [W-1:0] decSum;
    logic [W-1:0] diff;
    CNT_T         nextCount;

    always_comb begin
        sumUp     = {1'b0, count} + W'(inc);
        decSum    = W'(dec0) + W'(dec1);
        diff      = sumUp - decSum;
        nextCount = diff[CNTW-1:0];
        fault     = 1'b0;
        if (sumUp < decSum) begin
            // More retirements than pending writes: clamp at empty.
            nextCount = '0;
            fault     = 1'b1;
        end else if (diff > W'(CNT_MAX)) begin
            nextCount = CNT_MAX;
            fault     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= nextCount;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard; stall while a used source has an unretired write.
// Define HAZARD_SCOREBOARD_STATS_EN to add the stall_cycles statistics output.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     id_valid,
    input  REG_SEL_T rs_sel,
    input  logic     rs_used,
    input  REG_SEL_T rt_sel,
    input  logic     rt_used,
    input  REG_SEL_T dst_sel,
    input  logic     dst_en,
    input  REG_SEL_T wb_sel,
    input  logic     wb_en,
    input  REG_SEL_T kill_sel,
    input  logic     kill_en,
    output logic     stall,
    output logic     err
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    CNT_T            pend [NREG];
    logic [NREG-1:0] incVec;
    logic [NREG-1:0] wbVec;
    logic [NREG-1:0] killVec;
    logic [NREG-1:0] faultVec;
    logic            rsHit;
    logic            rtHit;
    logic            issue;

    // A writeback this cycle is forwarded by the register file, so it hides one pending write.
    function automatic logic hit(input CNT_T cnt, input logic wbHere);
        return cnt > CNT_T'(wbHere);
    endfunction

    always_comb begin
        rsHit = hit(pend[rs_sel], wb_en && (wb_sel == rs_sel));
        rtHit = hit(pend[rt_sel], wb_en && (wb_sel == rt_sel));
        stall = id_valid && ((rs_used && rsHit) || (rt_used && rtHit));
        issue = id_valid && !stall && dst_en;
    end

    always_comb begin
        incVec  = '0;
        wbVec   = '0;
        killVec = '0;
        incVec[dst_sel]  = issue;
        wbVec[wb_sel]    = wb_en;
        killVec[kill_sel] = kill_en;
    end

    for (genvar r = 0; r < NREG; r++) begin : genCnt
        scbd_counter uCnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (incVec[r]),
            .dec0  (wbVec[r]),
            .dec1  (killVec[r]),
            .count (pend[r]),
            .fault (faultVec[r])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (|faultVec) begin
            err <= 1'b1;
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
// Pending counts are inferred from stall behaviour under controlled writebacks.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [2:0] rs_sel;
    logic       rs_used;
    logic [2:0] rt_sel;
    logic       rt_used;
    logic [2:0] dst_sel;
    logic       dst_en;
    logic [2:0] wb_sel;
    logic       wb_en;
    logic [2:0] kill_sel;
    logic       kill_en;
    logic       stall;
    logic       err;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [15:0] stall_cycles;
`endif

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk      (clk),
        .rst      (rst),
        .id_valid (id_valid),
        .rs_sel   (rs_sel),
        .rs_used  (rs_used),
        .rt_sel   (rt_sel),
        .rt_used  (rt_used),
        .dst_sel  (dst_sel),
        .dst_en   (dst_en),
        .wb_sel   (wb_sel),
        .wb_en    (wb_en),
        .kill_sel (kill_sel),
        .kill_en  (kill_en),
        .stall    (stall),
        .err      (err)
`ifdef HAZARD_SCOREBOARD_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic clrIn();
        id_valid = 0; rs_sel = 0; rs_used = 0;
        rt_sel = 0; rt_used = 0; dst_sel = 0; dst_en = 0;
        wb_sel = 0; wb_en = 0; kill_sel = 0; kill_en = 0;
    endtask

    task automatic issue(input logic [2:0] d);
        clrIn();
        id_valid = 1; dst_en = 1; dst_sel = d;
        @(negedge clk);
        clrIn();
    endtask

    task automatic doRst();
        clrIn();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++; $display("FAIL reset_stall got %b want 0", stall);
        end
        nChecks++;
        if (err !== 1'b0) begin
            nFail++; $display("FAIL reset_err got %b want 0", err);
        end
        issue(3);
        issue(3);
        id_valid = 1; rs_sel = 3; rs_used = 1;
        #1;
        nChecks++;
        if (stall !== 1'b1) begin
            nFail++; $display("FAIL pre_reset_stall got %b want 1", stall);
        end
        #1 rst = 1;
        #1;
        nChecks++;
        if (stall !== 1'b0 || err !== 1'b0) begin
            nFail++; $display("FAIL async_reset got stall=%b err=%b want 0 0", stall, err);
        end
        @(negedge clk);
        rst = 0;
        #1;
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++; $display("FAIL post_reset_stall got %b want 0", stall);
        end
        clrIn();
        @(negedge clk);
    endtask

    task automatic test_raw();
        id_valid = 1; dst_en = 1; dst_sel = 2;
        #1;
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++; $display("FAIL raw_issue_stall got %b want 0", stall);
        end
        @(negedge clk);
        clrIn();
        id_valid = 1; rs_sel = 2; rs_used = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            nChecks++;
            if (stall !== 1'b1) begin
                nFail++; $display("FAIL raw_stall%0d got %b want 1", i, stall);
            end
            @(negedge clk);
        end
        wb_en = 1; wb_sel = 2;
        #1;
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++; $display("FAIL raw_wb_release got %b want 0", stall);
        end
        @(negedge clk);
        wb_en = 0;
        #1;
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++; $display("FAIL raw_after_wb got %b want 0", stall);
        end
        clrIn();
        @(negedge clk);
    endtask

    task automatic test_bypass();
        issue(5);
        id_valid = 1; rt_sel = 5; rt_used = 1;
        #1;
        nChecks++;
        if (stall !== 1'b1) begin
            nFail++; $display("FAIL bypass_pre got %b want 1", stall);
        end
        @(negedge clk);
        wb_en = 1; wb_sel = 5;
        #1;
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++; $display("FAIL bypass_same_cycle got %b want 0", stall);
        end
        @(negedge clk);
        wb_en = 0;
        #1;
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++; $display("FAIL bypass_cleared got %b want 0", stall);
        end
        clrIn();
        @(negedge clk);
    endtask

    task automatic test_unused();
        issue(4);
        id_valid = 1; rs_sel = 4; rs_used = 0; dst_en = 1; dst_sel = 4;
        #1;
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++; $display("FAIL unused_operand got %b want 0", stall);
        end
        @(negedge clk);
        clrIn();
        id_valid = 1; rs_sel = 4; rs_used = 1; wb_en = 1; wb_sel = 4;
        #1;
        nChecks++;
        if (stall !== 1'b1) begin
            nFail++; $display("FAIL unused_pend2 got %b want 1", stall);
        end
        @(negedge clk);
        #1;
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++; $display("FAIL unused_pend1_wb got %b want 0", stall);
        end
        @(negedge clk);
        wb_en = 0;
        #1;
        nChecks++;
        if (stall !== 1'b0 || err !== 1'b0) begin
            nFail++; $display("FAIL unused_drained got stall=%b err=%b want 0 0", stall, err);
        end
        clrIn();
        @(negedge clk);
    endtask

    task automatic test_kill();
        issue(6);
        issue(6);
        id_valid = 1; rs_sel = 6; rs_used = 1;
        kill_en = 1; kill_sel = 6; wb_en = 1; wb_sel = 6;
        #1;
        nChecks++;
        if (stall !== 1'b1) begin
            nFail++; $display("FAIL kill_wb_cycle got %b want 1", stall);
        end
        @(negedge clk);
        kill_en = 0; wb_en = 0;
        #1;
        nChecks++;
        if (stall !== 1'b0 || err !== 1'b0) begin
            nFail++; $display("FAIL kill_wb_after got stall=%b err=%b want 0 0", stall, err);
        end
        clrIn();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        issue(1);
        id_valid = 1; rs_sel = 1; rs_used = 1; dst_en = 1; dst_sel = 2;
        #1;
        nChecks++;
        if (stall !== 1'b1) begin
            nFail++; $display("FAIL b2b_stall got %b want 1", stall);
        end
        @(negedge clk);
        wb_en = 1; wb_sel = 1;
        #1;
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++; $display("FAIL b2b_release got %b want 0", stall);
        end
        @(negedge clk);
        clrIn();
        id_valid = 1; rs_sel = 2; rs_used = 1;
        #1;
        nChecks++;
        if (stall !== 1'b1) begin
            nFail++; $display("FAIL b2b_dst_pending got %b want 1", stall);
        end
        wb_en = 1; wb_sel = 2;
        #1;
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++; $display("FAIL b2b_single_issue got %b want 0", stall);
        end
        @(negedge clk);
        clrIn();
        #1;
        nChecks++;
        if (err !== 1'b0) begin
            nFail++; $display("FAIL b2b_err got %b want 0", err);
        end
        @(negedge clk);
    endtask

    task automatic test_err();
        wb_en = 1; wb_sel = 1;
        @(negedge clk);
        clrIn();
        #1;
        nChecks++;
        if (err !== 1'b1) begin
            nFail++; $display("FAIL underflow_err got %b want 1", err);
        end
        @(negedge clk);
        #1;
        nChecks++;
        if (err !== 1'b1) begin
            nFail++; $display("FAIL err_sticky got %b want 1", err);
        end
        doRst();
        #1;
        nChecks++;
        if (err !== 1'b0) begin
            nFail++; $display("FAIL err_cleared got %b want 0", err);
        end
        @(negedge clk);
        issue(7);
        issue(7);
        issue(7);
        #1;
        nChecks++;
        if (err !== 1'b0) begin
            nFail++; $display("FAIL full_no_err got %b want 0", err);
        end
        issue(7);
        #1;
        nChecks++;
        if (err !== 1'b1) begin
            nFail++; $display("FAIL overflow_err got %b want 1", err);
        end
        // Saturated at 3: two covered writebacks still stall, the third releases.
        id_valid = 1; rs_sel = 7; rs_used = 1; wb_en = 1; wb_sel = 7;
        for (int i = 0; i < 3; i++) begin
            #1;
            nChecks++;
            if (stall !== (i < 2)) begin
                nFail++; $display("FAIL sat_drain%0d got %b want %b", i, stall, i < 2);
            end
            @(negedge clk);
        end
        wb_en = 0;
        #1;
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++; $display("FAIL sat_empty got %b want 0", stall);
        end
        clrIn();
        @(negedge clk);
    endtask

`ifdef HAZARD_SCOREBOARD_STATS_EN
    task automatic test_stats();
        doRst();
        issue(0);
        id_valid = 1; rs_sel = 0; rs_used = 1;
        repeat (5) @(negedge clk);
        clrIn();
        wb_en = 1; wb_sel = 0;
        #1;
        nChecks++;
        if (stall_cycles !== 16'd5) begin
            nFail++; $display("FAIL stall_cycles got %0d want 5", stall_cycles);
        end
        @(negedge clk);
        clrIn();
    endtask
`endif

    initial begin
        clrIn();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        test_reset();
        test_raw();
        test_bypass();
        test_unused();
        test_kill();
        test_back_to_back();
        test_err();
`ifdef HAZARD_SCOREBOARD_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
